i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the I2C controller (2..8).
REQ-002 SHALL have parameter RETRY_MAX, default 3, maximum automatic re-issues after a NACK (used only with I2C_ARB_RETRY_EN).
REQ-003 SHALL have port sys_clock, input, 1, the single system clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req, input, N_REQ, per-requester transaction request, held until its done pulse.
REQ-006 SHALL have port req_ctrl, input, 32*N_REQ, packed 32-bit I2C control words; requester i occupies bits [32*i+31:32*i].
REQ-007 SHALL have port gnt, output, N_REQ, one-hot grant, held for the whole transaction.
REQ-008 SHALL have port done, output, N_REQ, one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port rsp_status, output, 32, controller status captured at completion; valid in the done cycle and held until the next completion.
REQ-010 SHALL have port i2c_ctrl_data, output, 32, control word to the I2C controller.
REQ-011 SHALL have port i2c_wr_ctrl, output, 1, control-register write strobe to the I2C controller.
REQ-012 SHALL have port i2c_status, input, 32, controller status: bit 31 busy, 30 address NACK, 29 data NACK, 26 initializing.

Function
REQ-013 SHALL use states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE and RESPOND.
REQ-014 In IDLE, when any req bit is set and i2c_status[31]=0, SHALL grant round-robin, searching from (last granted index + 1) mod N_REQ, and go to ISSUE.
REQ-015 SHALL not grant while i2c_status[31]=1, including the post-reset initializing period.
REQ-016 In ISSUE, SHALL drive i2c_ctrl_data = granted req_ctrl word and i2c_wr_ctrl = 1 for exactly one cycle, then go to WAIT_BUSY.
REQ-017 SHALL never assert i2c_wr_ctrl while i2c_status[31]=1 is sampled.
REQ-018 In WAIT_BUSY, SHALL wait for i2c_status[31]=1, then go to WAIT_DONE.
REQ-019 In WAIT_DONE, SHALL wait for i2c_status[31]=0, capture i2c_status into rsp_status, then go to RESPOND.
REQ-020 In RESPOND, SHALL pulse done at the granted index for one cycle, drop gnt in the following cycle, update the round-robin pointer, and return to IDLE.
REQ-021 Completion to re-grant SHALL take at least 1 idle cycle; a requester that holds req is re-granted only after the other pending requesters have been served.
REQ-022 A req deassertion mid-transaction SHALL be ignored: the transaction completes and done still pulses.
REQ-023 req_ctrl changes after ISSUE SHALL have no effect on the transaction in flight.
REQ-024 With a single requester, it SHALL be granted every transaction.

Reset
REQ-025 While reset_n=0: state IDLE, gnt=0, done=0, rsp_status=0, i2c_ctrl_data=0, i2c_wr_ctrl=0, pointer = N_REQ-1 (so requester 0 is searched first), retry count 0.
REQ-026 A reset assertion mid-transaction SHALL abort it with no done pulse.

Configuration
REQ-027 With I2C_ARB_RETRY_EN defined, a completion showing i2c_status[30] or [29] set SHALL return to ISSUE instead of RESPOND, at most RETRY_MAX times; after that, or on a clean status, RESPOND with the last captured status.
REQ-028 Without I2C_ARB_RETRY_EN, every completion SHALL go to RESPOND, and no retry counter SHALL exist.

Structure
REQ-029 Package i2c_arb_pkg SHALL hold the state enum and the status bit index constants (BUSY=31, ANACK=30, DNACK=29, INIT=26).
REQ-030 Sub-module rr_pick SHALL implement the combinational round-robin select (req, pointer -> one-hot grant).

Verification
REQ-031 Reset; i2c_status=32'h84000000 for 100 cycles with req=4'b0001 -> no gnt and no i2c_wr_ctrl until bit 31 clears.
REQ-032 req=4'b0001, req_ctrl[31:0]=32'h0050_1234, controller model busy for 50 cycles -> i2c_ctrl_data=32'h00501234 with a single-cycle wr_ctrl, done[0] pulses once, rsp_status=32'h00000000.
REQ-033 req=4'b1111 held continuously -> grants in order 0,1,2,3,0, each with one done pulse.
REQ-034 req[2] dropped during WAIT_DONE -> transaction completes, done[2] pulses, next grant goes to the next pending requester.
REQ-035 With I2C_ARB_RETRY_EN and RETRY_MAX=3, model returns status 32'h40000000 every time -> 4 wr_ctrl pulses, then done with rsp_status=32'h40000000; without the macro -> 1 wr_ctrl pulse.
REQ-036 reset_n pulsed low during WAIT_DONE -> all outputs return to reset values, no done pulse.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// Shared types and constants for the I2C controller arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    RESPOND
  } arb_state_t;

  // Bit positions inside the controller status word
  localparam int BUSY  = 31;
  localparam int ANACK = 30;
  localparam int DNACK = 29;
  localparam int INIT  = 26;

  // True when the controller reports an address or data NACK
  function automatic logic is_nack(input logic [31:0] status);
    return status[ANACK] | status[DNACK];
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin select: first set req bit after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when to accept the pick.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] gnt_idx
);

  logic [PTR_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = PTR_W'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Shares one I2C controller among N_REQ requesters, round-robin, one transaction at a time.
// Latency: grant 1 cycle after req with controller idle; done 1 cycle after controller goes idle.
// Backpressure: never grants or writes while status busy; optional NACK re-issue with I2C_ARB_RETRY_EN.
module i2c_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int RETRY_MAX = 3
) (
  input  logic                 sys_clock,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_ctrl,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic [31:0]          rsp_status,
  output logic [31:0]          i2c_ctrl_data,
  output logic                 i2c_wr_ctrl,
  input  logic [31:0]          i2c_status
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic [31:0]      pick_word;
  logic             busy;
  logic             start;
  logic             finish;
  logic             retry;

  assign busy   = i2c_status[BUSY];
  assign start  = (state_q == IDLE) && (|req) && !busy;
  assign finish = (state_q == WAIT_DONE) && !busy;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

`ifdef I2C_ARB_RETRY_EN
  localparam int RC_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
  logic [RC_W-1:0] retry_cnt;

  assign retry = is_nack(i2c_status) && (retry_cnt != RC_W'(RETRY_MAX));

  // Count re-issues of the current transaction; cleared on each new grant
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt <= '0;
    end else if (start) begin
      retry_cnt <= '0;
    end else if (finish && retry) begin
      retry_cnt <= retry_cnt + RC_W'(1);
    end
  end
`else
  assign retry = 1'b0;
`endif

  // Select the control word of the requester about to be granted
  always_comb begin
    pick_word = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == PTR_W'(i)) pick_word = req_ctrl[32*i +: 32];
    end
  end

  // State register
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; ISSUE holds off while the controller reports busy
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start)  state_d = ISSUE;
      ISSUE:     if (!busy)  state_d = WAIT_BUSY;
      WAIT_BUSY: if (busy)   state_d = WAIT_DONE;
      WAIT_DONE: if (finish) state_d = retry ? ISSUE : RESPOND;
      RESPOND:               state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // Outputs decoded from state: write strobe in ISSUE, done pulse in RESPOND
  always_comb begin
    i2c_wr_ctrl = (state_q == ISSUE) && !busy;
    done        = (state_q == RESPOND) ? gnt : '0;
  end

  // Grant, latched control word, captured status and round-robin pointer
  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt           <= '0;
      gnt_idx       <= '0;
      ptr           <= PTR_W'(N_REQ - 1);
      i2c_ctrl_data <= '0;
      rsp_status    <= '0;
    end else begin
      if (start) begin
        gnt           <= pick_gnt;
        gnt_idx       <= pick_idx;
        i2c_ctrl_data <= pick_word;
      end
      if (finish) begin
        rsp_status <= i2c_status;
      end
      if (state_q == RESPOND) begin
        gnt <= '0;
        ptr <= gnt_idx;
      end
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Self-checking bench for i2c_arbiter with a simple I2C controller model.
// Latency: n/a.
// Backpressure: n/a.
module tb_i2c_arbiter;

  localparam int N = 4;

  logic            sys_clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_ctrl;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic [31:0]     rsp_status;
  logic [31:0]     i2c_ctrl_data;
  logic            i2c_wr_ctrl;
  logic [31:0]     i2c_status;

  always #5 sys_clock = ~sys_clock;

  i2c_arbiter #(.N_REQ(N), .RETRY_MAX(3)) dut (
    .sys_clock     (sys_clock),
    .reset_n       (reset_n),
    .req           (req),
    .req_ctrl      (req_ctrl),
    .gnt           (gnt),
    .done          (done),
    .rsp_status    (rsp_status),
    .i2c_ctrl_data (i2c_ctrl_data),
    .i2c_wr_ctrl   (i2c_wr_ctrl),
    .i2c_status    (i2c_status)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  // Controller model: busy from the negedge after a write, for busy_len cycles
  logic        init_hold     = 1'b0;
  logic [31:0] m_status      = 32'h0;
  logic [31:0] m_done_status = 32'h0;
  int          m_cnt         = 0;
  int          busy_len      = 50;
  bit          m_start       = 1'b0;

  assign i2c_status = init_hold ? 32'h8400_0000 : m_status;

  always @(negedge sys_clock) begin
    if (m_start) begin
      m_status = 32'h8000_0000;
      m_cnt    = busy_len;
      m_start  = 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_status = m_done_status;
    end
    if (i2c_wr_ctrl) m_start = 1'b1;
  end

  // Scoreboard: expected completions in order
  typedef struct {
    int          idx;
    logic [31:0] ctrl;
    logic [31:0] status;
  } exp_t;

  exp_t exp_q[$];
  int   done_cnt = 0;
  int   wr_cnt   = 0;
  logic wr_prev  = 1'b0;

  always @(negedge sys_clock) begin
    if (i2c_wr_ctrl) begin
      wr_cnt++;
      check("wr_while_busy", 32'(i2c_status[31]), 32'h0);
      check("wr_single_cycle", 32'(wr_prev), 32'h0);
      if (exp_q.size() == 0) check("wr_unexpected", 32'(i2c_wr_ctrl), 32'h0);
      else                   check("wr_ctrl_data", i2c_ctrl_data, exp_q[0].ctrl);
    end
    wr_prev = i2c_wr_ctrl;
    if (done != '0) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 32'(done), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_idx", 32'(done), 32'(1) << e.idx);
        check("gnt_at_done", 32'(gnt), 32'(done));
        check("rsp_status", rsp_status, e.status);
      end
    end
  end

  task automatic push_exp(input int idx, input logic [31:0] status);
    exp_t e;
    e.idx    = idx;
    e.ctrl   = req_ctrl[32*idx +: 32];
    e.status = status;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input int target);
    int k = 0;
    while (done_cnt < target && k < 3000) begin
      @(negedge sys_clock);
      #1;
      k++;
    end
    check("wait_done", 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_busy_gnt(input logic [N-1:0] g);
    int k = 0;
    while (!(gnt == g && i2c_status[31]) && k < 3000) begin
      @(negedge sys_clock);
      #1;
      k++;
    end
    check("reach_wait_done", 32'(gnt), 32'(g));
  endtask

  task automatic do_reset();
    @(negedge sys_clock);
    reset_n = 1'b0;
    repeat (3) @(negedge sys_clock);
    reset_n = 1'b1;
    @(negedge sys_clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},  32'(gnt), 32'h0);
    check({tag, "_done"}, 32'(done), 32'h0);
    check({tag, "_rsp"},  rsp_status, 32'h0);
    check({tag, "_data"}, i2c_ctrl_data, 32'h0);
    check({tag, "_wr"},   32'(i2c_wr_ctrl), 32'h0);
  endtask

  initial begin
    int   base_wr;
    int   base_done;
    logic bad_g;
    logic bad_w;

    reset_n  = 1'b0;
    req      = '0;
    for (int i = 0; i < N; i++) req_ctrl[32*i +: 32] = 32'hA000_0000 | 32'(i);
    init_hold = 1'b1;
    repeat (3) @(negedge sys_clock);
    check_reset_outputs("reset");

    // Controller initializing: no grant and no write while busy
    reset_n = 1'b1;
    req_ctrl[31:0] = 32'h0050_1234;
    req   = 4'b0001;
    bad_g = 1'b0;
    bad_w = 1'b0;
    repeat (100) begin
      @(negedge sys_clock);
      if (gnt != '0) bad_g = 1'b1;
      if (i2c_wr_ctrl) bad_w = 1'b1;
    end
    check("init_no_gnt", 32'(bad_g), 32'h0);
    check("init_no_wr", 32'(bad_w), 32'h0);

    // Single transaction, controller busy for 50 cycles
    busy_len      = 50;
    m_done_status = 32'h0;
    push_exp(0, 32'h0);
    base_wr   = wr_cnt;
    init_hold = 1'b0;
    wait_done(1);
    req = '0;
    repeat (3) @(negedge sys_clock);
    check("single_wr_count", 32'(wr_cnt - base_wr), 32'd1);
    check("single_gnt_dropped", 32'(gnt), 32'h0);
    check("single_rsp_held", rsp_status, 32'h0);

    // All four requesting continuously: order 0,1,2,3,0
    do_reset();
    req_ctrl[31:0] = 32'hA000_0000;
    busy_len       = 5;
    m_done_status  = 32'h0000_00A5;
    base_done      = done_cnt;
    push_exp(0, 32'hA5); push_exp(1, 32'hA5); push_exp(2, 32'hA5);
    push_exp(3, 32'hA5); push_exp(0, 32'hA5);
    req = 4'b1111;
    wait_done(base_done + 5);
    req = '0;
    repeat (20) @(negedge sys_clock);
    check("rr_no_extra_done", 32'(done_cnt), 32'(base_done + 5));

    // req[2] dropped mid-transaction; next grant wraps to requester 0
    do_reset();
    busy_len      = 12;
    m_done_status = 32'h0000_0011;
    base_done     = done_cnt;
    push_exp(0, 32'h11); push_exp(2, 32'h11); push_exp(0, 32'h11);
    req = 4'b0101;
    wait_busy_gnt(4'b0100);
    repeat (3) @(negedge sys_clock);
    req[2] = 1'b0;
    wait_done(base_done + 3);
    req = '0;
    repeat (20) @(negedge sys_clock);
    check("drop_no_extra_done", 32'(done_cnt), 32'(base_done + 3));

    // NACK on every completion; control word change after issue is ignored
    do_reset();
    busy_len      = 6;
    m_done_status = 32'h4000_0000;
    base_done     = done_cnt;
    base_wr       = wr_cnt;
    push_exp(1, 32'h4000_0000);
    req = 4'b0010;
    wait_busy_gnt(4'b0010);
    req_ctrl[63:32] = 32'hDEAD_BEEF;
    wait_done(base_done + 1);
    req = '0;
    repeat (5) @(negedge sys_clock);
`ifdef I2C_ARB_RETRY_EN
    check("nack_wr_count", 32'(wr_cnt - base_wr), 32'd4);
`else
    check("nack_wr_count", 32'(wr_cnt - base_wr), 32'd1);
`endif
    check("nack_rsp_held", rsp_status, 32'h4000_0000);

    // Reset during WAIT_DONE aborts with no done pulse
    busy_len      = 30;
    m_done_status = 32'h0;
    req_ctrl[31:0] = 32'h0000_5A5A;
    base_done     = done_cnt;
    push_exp(0, 32'h0);
    req = 4'b0001;
    wait_busy_gnt(4'b0001);
    repeat (5) @(negedge sys_clock);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("abort");
    req = '0;
    void'(exp_q.pop_back());
    repeat (3) @(negedge sys_clock);
    reset_n = 1'b1;
    repeat (50) @(negedge sys_clock);
    check("abort_no_done", 32'(done_cnt), 32'(base_done));
    check("abort_gnt_idle", 32'(gnt), 32'h0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
